// File: rtl/snn_input_loader.sv
// -----------------------------------------------------------------------------
// snn_input_loader
//
// Takes bytes from the UART receiver and unpacks each one, LSB first, into a
// 1-bit-wide input-image memory for the SNN core. A frame is NUM_BYTES bytes.
// Each bit goes to bit address byte_index*8 + bit_index. When the last bit has
// been written, frame_done pulses and the loader waits in HOLD until the core
// returns frame_ack. While it waits, the buffer is left untouched.
//
// A single byte that arrives while another byte is still being unpacked is
// parked in a one-deep hold buffer. A second early byte is an overrun and
// aborts the frame. If the gap between bytes inside a frame exceeds
// TIMEOUT_CYC clocks, the frame is also aborted.
//
// Optional feature (compile-time macro SNN_LOADER_CHECKSUM_EN):
//   When defined, one extra trailing checksum byte follows the data bytes.
//   The frame is accepted only if the 8-bit sum of all data bytes plus that
//   checksum byte is 8'h00. The checksum byte is not written to memory.
//   When undefined, the loader has no CHECK state and no accumulator.
//
// Parameters
//   NUM_BYTES    data bytes per frame (NUM_BYTES*8 <= 2**ADDR_W)
//   ADDR_W       width of wr_addr
//   TIMEOUT_CYC  maximum clk cycles between bytes inside a frame
//
// Ports
//   clk          in   system clock
//   rst_n        in   asynchronous, active-low reset
//   rx_rdy       in   one-cycle pulse: rx_data holds a received byte
//   rx_data      in   [7:0] received byte
//   frame_ack    in   SNN core has consumed the buffer (used only in HOLD)
//   wr_en        out  input-memory write strobe (high only while unpacking)
//   wr_addr      out  [ADDR_W-1:0] input-memory bit address
//   wr_data      out  pixel bit to write
//   busy         out  high in every state except IDLE
//   frame_done   out  one-cycle pulse on the first cycle of HOLD
//   frame_err    out  one-cycle pulse on the cycle after an abort (now IDLE)
// -----------------------------------------------------------------------------
module snn_input_loader #(
  parameter int NUM_BYTES   = 98,
  parameter int ADDR_W      = 10,
  parameter int TIMEOUT_CYC = 500000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  input  logic              frame_ack,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err
);

  localparam int BC_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(NUM_BYTES - 1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYC - 1);

`ifdef SNN_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, UNPACK, COLLECT, CHECK, HOLD} state_t;
`else
  typedef enum logic [2:0] {IDLE, UNPACK, COLLECT, HOLD} state_t;
`endif

  state_t            state, state_nx;
  logic [7:0]        shift_q, shift_nx;
  logic [7:0]        hold_buf, hold_buf_nx;
  logic              hold_full, hold_full_nx;
  logic [BC_W-1:0]   byte_cnt, byte_cnt_nx;
  logic [2:0]        bit_cnt, bit_cnt_nx;
  logic [TO_W-1:0]   to_cnt, to_cnt_nx;
  logic              done_nx, err_nx;
  logic              unpack;
  logic [BC_W+2:0]   addr_full;

`ifdef SNN_LOADER_CHECKSUM_EN
  logic [7:0]        sum_q, sum_nx;

  // Running modulo-256 sum of the data bytes.
  function automatic logic [7:0] sum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  // A frame is good when the data sum plus the checksum byte wraps to zero.
  function automatic logic chk_ok(input logic [7:0] acc, input logic [7:0] chk);
    logic [7:0] t;
    t = acc + chk;
    return (t == 8'h00);
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // Next-state / datapath decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nx     = state;
    shift_nx     = shift_q;
    hold_buf_nx  = hold_buf;
    hold_full_nx = hold_full;
    byte_cnt_nx  = byte_cnt;
    bit_cnt_nx   = bit_cnt;
    to_cnt_nx    = to_cnt;
    done_nx      = 1'b0;
    err_nx       = 1'b0;
`ifdef SNN_LOADER_CHECKSUM_EN
    sum_nx       = sum_q;
`endif

    unique case (state)
      IDLE: begin
        bit_cnt_nx   = 3'd0;
        hold_full_nx = 1'b0;
        if (rx_rdy) begin
          shift_nx    = rx_data;
          byte_cnt_nx = '0;
          state_nx    = UNPACK;
`ifdef SNN_LOADER_CHECKSUM_EN
          sum_nx      = rx_data;
`endif
        end
      end

      UNPACK: begin
        shift_nx   = {1'b0, shift_q[7:1]};
        bit_cnt_nx = bit_cnt + 3'd1;
        if (rx_rdy && hold_full) begin
          // A second byte is pending while one is already parked: overrun.
          // This is checked first, so it also wins on the bit-7 cycle.
          err_nx       = 1'b1;
          hold_full_nx = 1'b0;
          state_nx     = IDLE;
        end else begin
          if (rx_rdy) begin
            hold_buf_nx  = rx_data;
            hold_full_nx = 1'b1;
          end
          if (bit_cnt == 3'd7) begin
            if (byte_cnt == LAST_BYTE) begin
`ifdef SNN_LOADER_CHECKSUM_EN
              // A checksum byte that arrived early stays parked for CHECK.
              to_cnt_nx = '0;
              state_nx  = CHECK;
`else
              hold_full_nx = 1'b0;
              done_nx      = 1'b1;
              state_nx     = HOLD;
`endif
            end else begin
              byte_cnt_nx = byte_cnt + 1'b1;
              if (hold_full) begin
                shift_nx     = hold_buf;
                hold_full_nx = 1'b0;
`ifdef SNN_LOADER_CHECKSUM_EN
                sum_nx       = sum_add(sum_q, hold_buf);
`endif
              end else if (rx_rdy) begin
                // A byte that lands on the last bit cycle goes straight into
                // the shifter. This avoids a trip through COLLECT.
                shift_nx     = rx_data;
                hold_full_nx = 1'b0;
`ifdef SNN_LOADER_CHECKSUM_EN
                sum_nx       = sum_add(sum_q, rx_data);
`endif
              end else begin
                to_cnt_nx = '0;
                state_nx  = COLLECT;
              end
            end
          end
        end
      end

      COLLECT: begin
        to_cnt_nx = to_cnt + 1'b1;
        if (rx_rdy) begin
          // If a byte and the timeout land on the same cycle, the byte wins.
          shift_nx = rx_data;
          state_nx = UNPACK;
`ifdef SNN_LOADER_CHECKSUM_EN
          sum_nx   = sum_add(sum_q, rx_data);
`endif
        end else if (to_cnt == TO_LAST) begin
          err_nx   = 1'b1;
          state_nx = IDLE;
        end
      end

`ifdef SNN_LOADER_CHECKSUM_EN
      CHECK: begin
        to_cnt_nx = to_cnt + 1'b1;
        if (hold_full || rx_rdy) begin
          hold_full_nx = 1'b0;
          if (chk_ok(sum_q, hold_full ? hold_buf : rx_data)) begin
            done_nx  = 1'b1;
            state_nx = HOLD;
          end else begin
            err_nx   = 1'b1;
            state_nx = IDLE;
          end
        end else if (to_cnt == TO_LAST) begin
          err_nx   = 1'b1;
          state_nx = IDLE;
        end
      end
`endif

      HOLD: begin
        // Bytes received while the core owns the buffer are discarded.
        hold_full_nx = 1'b0;
        if (frame_ack) begin
          state_nx = IDLE;
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      hold_full  <= 1'b0;
      byte_cnt   <= '0;
      bit_cnt    <= 3'd0;
      to_cnt     <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nx;
      hold_full  <= hold_full_nx;
      byte_cnt   <= byte_cnt_nx;
      bit_cnt    <= bit_cnt_nx;
      to_cnt     <= to_cnt_nx;
      frame_done <= done_nx;
      frame_err  <= err_nx;
    end
  end

  // ---------------------------------------------------------------------------
  // Data registers (their contents matter only while flagged valid)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    shift_q  <= shift_nx;
    hold_buf <= hold_buf_nx;
`ifdef SNN_LOADER_CHECKSUM_EN
    sum_q    <= sum_nx;
`endif
  end

  // ---------------------------------------------------------------------------
  // Outputs: the write port is gated by UNPACK, so the reset state drives zeros
  // ---------------------------------------------------------------------------
  assign unpack    = (state == UNPACK);
  assign addr_full = {byte_cnt, bit_cnt};
  assign wr_en     = unpack;
  assign wr_data   = unpack & shift_q[0];
  assign wr_addr   = unpack ? ADDR_W'(addr_full) : '0;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_snn_input_loader.sv
// -----------------------------------------------------------------------------
// tb_snn_input_loader
//
// Drives snn_input_loader with randomised and directed frames. For each frame,
// a queueing model of the loader works out when every write, frame_done and
// frame_err should happen. The model treats the loader as one 8-cycle server
// with one waiting slot, an inter-byte timeout and an end-of-frame event, and
// builds the list of expected events with their cycle numbers.
//
// Those expected events go into a scoreboard queue before the stimulus starts.
// A separate monitor pops and compares the queue on every wr_en, frame_done or
// frame_err it sees.
// -----------------------------------------------------------------------------
module tb_snn_input_loader;

  localparam int NB  = 98;
  localparam int AW  = 10;
  localparam int TMO = 200;
`ifdef SNN_LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif
  localparam int FL  = NB + (CHK_EN ? 1 : 0);
  localparam int BIG = 32'h3fff_ffff;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx_rdy;
  logic [7:0]    rx_data;
  logic          frame_ack;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          wr_data;
  logic          busy;
  logic          frame_done;
  logic          frame_err;

  snn_input_loader #(
    .NUM_BYTES  (NB),
    .ADDR_W     (AW),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_rdy    (rx_rdy),
    .rx_data   (rx_data),
    .frame_ack (frame_ack),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .frame_done(frame_done),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // cyc is the index of the current clock period (it advances at each posedge).
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;   // 0 write, 1 frame_done, 2 frame_err
    int per;
    int addr;
    int bitv;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] fd[$];   // bytes of the current frame
  int         fa[$];   // period in which each byte's rx_rdy is high
  int         n_chk  = 0;
  int         n_fail = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_evt(input int kind, input int addr, input int bitv);
    exp_t e;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind=%0d addr=%0d bit=%0d at cycle %0d, required no event",
               kind, addr, bitv, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.per != cyc || (kind == 0 && (e.addr != addr || e.bitv != bitv))) begin
        n_fail++;
        $display("FAIL event: got kind=%0d addr=%0d bit=%0d at cycle %0d, required kind=%0d addr=%0d bit=%0d at cycle %0d",
                 kind, addr, bitv, cyc, e.kind, e.addr, e.bitv, e.per);
      end
    end
  endtask

  // Monitor: every output event must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en)      check_evt(0, int'(wr_addr), int'(wr_data));
      if (frame_done) check_evt(1, 0, 0);
      if (frame_err)  check_evt(2, 0, 0);
    end
  end

  // Arrival times for n bytes. Each gap is random in [lo,hi], but a byte is
  // never sent before the previous byte has started unpacking, so no overrun.
  task automatic gen_times(input int n, input int lo, input int hi);
    int t, s, s_prev, e_prev;
    fa.delete();
    t = cyc + 2; s_prev = 0; e_prev = 0;
    for (int j = 0; j < n; j++) begin
      if (j > 0) begin
        t = t + 1 + int'($urandom_range(hi, lo));
        if (t < s_prev) t = s_prev;
      end
      s = (t + 1 > e_prev) ? t + 1 : e_prev;
      fa.push_back(t);
      s_prev = s; e_prev = s + 8;
    end
  endtask

  // Queueing model. A byte starts unpacking one cycle after it arrives, or
  // when the previous byte finishes, whichever is later. Unpacking takes
  // 8 cycles, one bit per cycle.
  //
  // A byte that arrives before its predecessor has started is an overrun.
  // A byte that arrives TMO or more cycles after the server went idle is
  // too late (timeout).
  //
  // Events at or after `cut` are suppressed; this models a reset.
  task automatic plan(input int cut);
    int n, s_prev, e_prev, s, fin, kind;
    logic [7:0] sum, tot;
    int st[$];
    n = fd.size(); s_prev = 0; e_prev = 0; fin = 0; kind = 0; sum = 8'h00;
    for (int j = 0; j < n && kind == 0; j++) begin
      if (j > 0 && fa[j] < s_prev) begin
        kind = 2; fin = fa[j] + 1;
      end else if (j > 0 && fa[j] >= e_prev + TMO) begin
        kind = 2; fin = e_prev + TMO;
      end else if (j >= NB) begin
        tot  = sum + fd[j];
        fin  = ((fa[j] > e_prev) ? fa[j] : e_prev) + 1;
        kind = (tot == 8'h00) ? 1 : 2;
      end else begin
        s = (j == 0) ? fa[0] + 1 : ((fa[j] + 1 > e_prev) ? fa[j] + 1 : e_prev);
        st.push_back(s);
        sum = sum + fd[j];
        s_prev = s; e_prev = s + 8;
      end
    end
    if (kind == 0) begin
      if (!CHK_EN && st.size() == NB) begin kind = 1; fin = e_prev; end
      else begin kind = 2; fin = e_prev + TMO; end
    end
    for (int j = 0; j < st.size(); j++)
      for (int i = 0; i < 8; i++)
        if (st[j] + i < fin && st[j] + i < cut)
          exp_q.push_back('{0, st[j] + i, j * 8 + i, int'(fd[j][i])});
    if (fin < cut) exp_q.push_back('{kind, fin, 0, 0});
  endtask

  task automatic drive(input bit noise);
    for (int j = 0; j < fd.size(); j++) begin
      while (cyc < fa[j]) tick();
      rx_data   = fd[j];
      rx_rdy    = 1'b1;
      frame_ack = noise ? 1'($urandom_range(1, 0)) : 1'b0;
      tick();
      rx_rdy    = 1'b0;
      frame_ack = 1'b0;
    end
  endtask

  task automatic drain(input string name, input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    check({name, "_pending"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic ack();
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
  endtask

  // Build a full frame from random data (or a constant), plus a checksum byte
  // when that feature is enabled.
  task automatic make_frame(input bit rnd, input logic [7:0] val);
    logic [7:0] sm;
    fd.delete(); sm = 8'h00;
    for (int j = 0; j < NB; j++) begin
      fd.push_back(rnd ? 8'($urandom) : val);
      sm = sm + fd[j];
    end
    if (CHK_EN) fd.push_back(8'h00 - sm);
  endtask

  task automatic random_frame(input string name);
    make_frame(1'b1, 8'h00);
    gen_times(FL, 0, 24);
    plan(BIG);
    drive(1'b1);
    drain(name, 400);
    check({name, "_busy_hold"}, int'(busy), 1);
    ack();
    check({name, "_busy_after_ack"}, int'(busy), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int r;
    rst_n = 1'b0; rx_rdy = 1'b0; rx_data = 8'h00; frame_ack = 1'b0;
    repeat (3) tick();
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_wr_addr", int'(wr_addr), 0);
    check("rst_wr_data", int'(wr_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_frame_err", int'(frame_err), 0);
    rst_n = 1'b1;
    tick(); tick();

    // Full frame of 8'hA5, evenly spaced.
    make_frame(1'b0, 8'hA5);
    gen_times(FL, 30, 30);
    plan(BIG);
    drive(1'b0);
    drain("a5_frame", 400);
    check("a5_busy_hold", int'(busy), 1);

    // Extra bytes while in HOLD must be ignored.
    for (int k = 0; k < 3; k++) begin
      rx_data = 8'($urandom); rx_rdy = 1'b1; tick(); rx_rdy = 1'b0;
      tick(); tick();
    end
    check("hold_extra_busy", int'(busy), 1);
    ack();
    check("hold_ack_busy", int'(busy), 0);

    for (int f = 0; f < 3; f++) random_frame($sformatf("rand%0d", f));

    // Ten bytes, then silence: the frame must time out.
    fd.delete();
    for (int j = 0; j < 10; j++) fd.push_back(8'($urandom));
    gen_times(10, 5, 20);
    plan(BIG);
    drive(1'b0);
    drain("timeout", TMO + 400);
    check("timeout_busy", int'(busy), 0);

    // Bytes at relative cycles 0, 2, 4: the third is an overrun.
    fd.delete(); fa.delete();
    for (int j = 0; j < 3; j++) begin
      fd.push_back(8'($urandom));
      fa.push_back(cyc + 2 + 2 * j);
    end
    plan(BIG);
    drive(1'b0);
    drain("overrun", 50);
    check("overrun_busy", int'(busy), 0);

`ifdef SNN_LOADER_CHECKSUM_EN
    make_frame(1'b0, 8'h01);
    fd[NB] = 8'h9E;
    gen_times(FL, 8, 16);
    plan(BIG);
    drive(1'b0);
    drain("chk_good", 400);
    check("chk_good_busy", int'(busy), 1);
    ack();
    make_frame(1'b0, 8'h01);
    fd[NB] = 8'h9F;
    gen_times(FL, 8, 16);
    plan(BIG);
    drive(1'b0);
    drain("chk_bad", 400);
    check("chk_bad_busy", int'(busy), 0);
`endif

    // Asynchronous reset while byte 5 is being unpacked.
    fd.delete();
    for (int j = 0; j < 6; j++) fd.push_back(8'($urandom));
    gen_times(6, 20, 20);
    r = fa[5] + 4;
    plan(r);
    drive(1'b0);
    while (cyc < r) tick();
    rst_n = 1'b0;
    #1;
    check("arst_wr_en", int'(wr_en), 0);
    check("arst_wr_addr", int'(wr_addr), 0);
    check("arst_wr_data", int'(wr_data), 0);
    check("arst_busy", int'(busy), 0);
    drain("arst_flush", 2);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    random_frame("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
